// File: rtl/alu_ctrl_mc_if.sv
// EX-stage ALU control bus: instruction decode inputs, MUL operands and
// the decode/sequencer outputs of alu_ctrl_mc.
//   master : drives valid_i, flush_i, ALUOp_i, funct_i, data1_i, data2_i
//   slave  : drives ALUCtrl_o, illegal_o, stall_o, done_o, mul_result_o
//            (and hi_o when ALU_CTRL_HI_EN is defined)
interface alu_ctrl_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_i;
  logic             flush_i;
  logic [2:0]       ALUOp_i;
  logic [5:0]       funct_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [2:0]       ALUCtrl_o;
  logic             illegal_o;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] mul_result_o;
`ifdef ALU_CTRL_HI_EN
  logic [WIDTH-1:0] hi_o;
`endif

  modport master (
`ifdef ALU_CTRL_HI_EN
    input  hi_o,
`endif
    output valid_i, flush_i, ALUOp_i, funct_i, data1_i, data2_i,
    input  ALUCtrl_o, illegal_o, stall_o, done_o, mul_result_o
  );

  modport slave (
`ifdef ALU_CTRL_HI_EN
    output hi_o,
`endif
    input  valid_i, flush_i, ALUOp_i, funct_i, data1_i, data2_i,
    output ALUCtrl_o, illegal_o, stall_o, done_o, mul_result_o
  );
endinterface

// File: rtl/alu_ctrl_mc.sv
// ALU control for the EX stage with an iterative shift-add multiplier.
// Decodes ALUOp/funct to a 3-bit ALU op (combinational), flags unknown
// R-type functs, and runs MUL over WIDTH/MUL_BPC cycles while stalling.
// Ports:
//   clk_i    : clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   bus      : alu_ctrl_mc_if.slave (decode inputs, operands, ALUCtrl_o,
//              illegal_o, stall_o comb; done_o, mul_result_o registered)
// Optional feature macro ALU_CTRL_HI_EN: adds registered hi_o (upper half
// of the unsigned product) and decodes funct 011001 (MULTU) as MUL.
module alu_ctrl_mc #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_BPC = 1
) (
  input logic        clk_i,
  input logic        rst_n_i,
  alu_ctrl_mc_if.slave bus
);
  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned STEPS = WIDTH / MUL_BPC;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [ACC_W-1:0]   pp_c;
  logic [2:0]         alu_ctrl_c;
  logic               funct_bad_c;
  logic               start_c;
  logic               stall_c;
`ifdef ALU_CTRL_HI_EN
  logic [WIDTH-1:0]   hi_q, hi_d;
`endif

  // ALU op decode; unknown functs fall back to ADD and are flagged.
  always_comb begin
    alu_ctrl_c  = OP_ADD;
    funct_bad_c = 1'b0;
    case (bus.ALUOp_i)
      3'b000: alu_ctrl_c = OP_ADD;
      3'b001: alu_ctrl_c = OP_SUB;
      default: begin
        case (bus.funct_i)
          6'b100000: alu_ctrl_c = OP_ADD;
          6'b100010: alu_ctrl_c = OP_SUB;
          6'b100100: alu_ctrl_c = OP_AND;
          6'b100101: alu_ctrl_c = OP_OR;
          6'b101010: alu_ctrl_c = OP_SLT;
          6'b011000: alu_ctrl_c = OP_MUL;
`ifdef ALU_CTRL_HI_EN
          6'b011001: alu_ctrl_c = OP_MUL;
`endif
          default:   funct_bad_c = 1'b1;
        endcase
      end
    endcase
  end

  // Reset gates start so stall_o drops the moment rst_n_i falls.
  assign start_c = rst_n_i & bus.valid_i & ~bus.flush_i &
                   (alu_ctrl_c == OP_MUL) & (state_q == S_IDLE);

  // Partial product for the MUL_BPC low multiplier bits of this step.
  always_comb begin
    pp_c = '0;
    for (int unsigned b = 0; b < MUL_BPC; b++) begin
      if (mplier_q[b]) pp_c = pp_c + (mcand_q << b);
    end
  end

  // Sequencer next-state and outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    done_d   = 1'b0;
    res_d    = res_q;
`ifdef ALU_CTRL_HI_EN
    hi_d     = hi_q;
`endif
    stall_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_c = start_c;
        if (start_c) begin
          mcand_d  = ACC_W'(bus.data1_i);
          mplier_d = bus.data2_i;
          acc_d    = '0;
          cnt_d    = CNT_W'(STEPS);
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          stall_c  = 1'b1;
          acc_d    = acc_q + pp_c;
          mcand_d  = mcand_q << MUL_BPC;
          mplier_d = mplier_q >> MUL_BPC;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            res_d   = acc_d[WIDTH-1:0];
`ifdef ALU_CTRL_HI_EN
            hi_d    = acc_d[ACC_W-1:WIDTH];
`endif
          end
        end
      end
      // The held MUL is still on the inputs here; never restart from DONE.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      done_q   <= 1'b0;
      res_q    <= '0;
`ifdef ALU_CTRL_HI_EN
      hi_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      done_q   <= done_d;
      res_q    <= res_d;
`ifdef ALU_CTRL_HI_EN
      hi_q     <= hi_d;
`endif
    end
  end

  assign bus.ALUCtrl_o    = alu_ctrl_c;
  assign bus.illegal_o    = bus.valid_i & funct_bad_c;
  assign bus.stall_o      = stall_c;
  assign bus.done_o       = done_q;
  assign bus.mul_result_o = res_q;
`ifdef ALU_CTRL_HI_EN
  assign bus.hi_o         = hi_q;
`endif
endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Testbench for alu_ctrl_mc: a WIDTH=32/MUL_BPC=1 instance and a
// WIDTH=16/MUL_BPC=4 instance, checked against a behavioural model.
module tb_alu_ctrl_mc;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_ctrl_mc_if #(.WIDTH(32)) bus32();
  alu_ctrl_mc_if #(.WIDTH(16)) bus16();

  alu_ctrl_mc #(.WIDTH(32), .MUL_BPC(1)) dut32 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus32));
  alu_ctrl_mc #(.WIDTH(16), .MUL_BPC(4)) dut16 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus16));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode: returns {unknown_funct, alu_op}.
  function automatic logic [3:0] ref_decode(input logic [2:0] op, input logic [5:0] f);
    if (op == 3'd0) return 4'b0_000;
    if (op == 3'd1) return 4'b0_001;
    case (f)
      6'h20: return 4'b0_000;
      6'h22: return 4'b0_001;
      6'h24: return 4'b0_010;
      6'h25: return 4'b0_011;
      6'h2A: return 4'b0_100;
      6'h18: return 4'b0_101;
`ifdef ALU_CTRL_HI_EN
      6'h19: return 4'b0_101;
`endif
      default: return 4'b1_000;
    endcase
  endfunction

  task automatic idle_inputs();
    bus32.valid_i = 1'b0; bus32.flush_i = 1'b0; bus32.ALUOp_i = 3'd0;
    bus32.funct_i = 6'd0; bus32.data1_i = '0;   bus32.data2_i = '0;
    bus16.valid_i = 1'b0; bus16.flush_i = 1'b0; bus16.ALUOp_i = 3'd0;
    bus16.funct_i = 6'd0; bus16.data1_i = '0;   bus16.data2_i = '0;
  endtask

  // Issue a MUL on the 32-bit instance at the next edge; returns in its DONE cycle.
  task automatic mul32(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    int lat;
    bit got;
    prod = 64'(a) * 64'(b);
    lat = 0; got = 1'b0;
    @(posedge clk); #1;
    bus32.valid_i = 1'b1; bus32.flush_i = 1'b0; bus32.ALUOp_i = 3'b010;
    bus32.funct_i = 6'h18; bus32.data1_i = a; bus32.data2_i = b;
    #1;
    check("mul32_start_stall", 64'(bus32.stall_o), 64'd1);
    check("mul32_decode", 64'(bus32.ALUCtrl_o), 64'd5);
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      bus32.data1_i = $urandom; bus32.data2_i = $urandom;
      #1;
      if (bus32.done_o === 1'b1) begin
        got = 1'b1;
        check("mul32_latency", 64'(lat), 64'd33);
        check("mul32_result", 64'(bus32.mul_result_o), 64'(prod[31:0]));
        check("mul32_done_stall", 64'(bus32.stall_o), 64'd0);
`ifdef ALU_CTRL_HI_EN
        check("mul32_hi", 64'(bus32.hi_o), 64'(prod[63:32]));
`endif
      end else begin
        check("mul32_busy_stall", 64'(bus32.stall_o), 64'd1);
      end
    end
    if (!got) check("mul32_timeout", 64'd0, 64'd1);
  endtask

  task automatic mul16(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] prod;
    int lat;
    bit got;
    prod = 32'(a) * 32'(b);
    lat = 0; got = 1'b0;
    @(posedge clk); #1;
    bus16.valid_i = 1'b1; bus16.flush_i = 1'b0; bus16.ALUOp_i = 3'b010;
    bus16.funct_i = 6'h18; bus16.data1_i = a; bus16.data2_i = b;
    #1;
    check("mul16_start_stall", 64'(bus16.stall_o), 64'd1);
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      bus16.data1_i = 16'($urandom); bus16.data2_i = 16'($urandom);
      #1;
      if (bus16.done_o === 1'b1) begin
        got = 1'b1;
        check("mul16_latency", 64'(lat), 64'd5);
        check("mul16_result", 64'(bus16.mul_result_o), 64'(prod[15:0]));
        check("mul16_done_stall", 64'(bus16.stall_o), 64'd0);
`ifdef ALU_CTRL_HI_EN
        check("mul16_hi", 64'(bus16.hi_o), 64'(prod[31:16]));
`endif
      end else begin
        check("mul16_busy_stall", 64'(bus16.stall_o), 64'd1);
      end
    end
    if (!got) check("mul16_timeout", 64'd0, 64'd1);
  endtask

  // Cycle after DONE: instruction retired, no restart must have happened.
  task automatic after_done32();
    @(posedge clk); #1;
    bus32.valid_i = 1'b0;
    #1;
    check("post_done_stall", 64'(bus32.stall_o), 64'd0);
    check("post_done_done", 64'(bus32.done_o), 64'd0);
    @(posedge clk); #2;
    check("post_done_idle", 64'(bus32.stall_o), 64'd0);
  endtask

  initial begin
    logic [5:0] legal_f [6];
    logic [3:0] exp_dec;
    int seen_done;
    legal_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18};

    idle_inputs();
    rst_n = 1'b0;
    #2;
    check("rst_done", 64'(bus32.done_o), 64'd0);
    check("rst_result", 64'(bus32.mul_result_o), 64'd0);
    check("rst_stall", 64'(bus32.stall_o), 64'd0);
`ifdef ALU_CTRL_HI_EN
    check("rst_hi", 64'(bus32.hi_o), 64'd0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // Directed decode sweep (flush held so MUL decode cannot start).
    @(posedge clk); #1;
    bus32.valid_i = 1'b1; bus32.flush_i = 1'b1; bus32.ALUOp_i = 3'b010;
    foreach (legal_f[i]) begin
      bus32.funct_i = legal_f[i];
      #1;
      exp_dec = ref_decode(3'b010, legal_f[i]);
      check("dec_legal_op", 64'(bus32.ALUCtrl_o), 64'(exp_dec[2:0]));
      check("dec_legal_ill", 64'(bus32.illegal_o), 64'd0);
      check("dec_flush_nostall", 64'(bus32.stall_o), 64'd0);
    end
    bus32.funct_i = 6'b000111; #1;
    check("dec_bad_op", 64'(bus32.ALUCtrl_o), 64'd0);
    check("dec_bad_ill", 64'(bus32.illegal_o), 64'd1);
    bus32.funct_i = 6'b011001; #1;
`ifdef ALU_CTRL_HI_EN
    check("dec_multu", 64'(bus32.ALUCtrl_o), 64'd5);
    check("dec_multu_ill", 64'(bus32.illegal_o), 64'd0);
`else
    check("dec_multu_ill", 64'(bus32.illegal_o), 64'd1);
`endif
    bus32.flush_i = 1'b0;
    bus32.ALUOp_i = 3'b000; bus32.funct_i = 6'h18; #1;
    check("dec_op0_add", 64'(bus32.ALUCtrl_o), 64'd0);
    check("dec_op0_nostall", 64'(bus32.stall_o), 64'd0);
    bus32.ALUOp_i = 3'b001; bus32.funct_i = 6'b000111; #1;
    check("dec_op1_sub", 64'(bus32.ALUCtrl_o), 64'd1);
    check("dec_op1_ill", 64'(bus32.illegal_o), 64'd0);

    // Random decode; MUL decodes are paired with flush so state stays IDLE.
    for (int k = 0; k < 40; k++) begin
      bus32.ALUOp_i = 3'($urandom);
      bus32.funct_i = ($urandom_range(0, 1) == 0) ? legal_f[$urandom_range(0, 5)] : 6'($urandom);
      bus32.valid_i = 1'($urandom);
      exp_dec = ref_decode(bus32.ALUOp_i, bus32.funct_i);
      bus32.flush_i = (exp_dec[2:0] == 3'b101) ? 1'b1 : 1'($urandom);
      #1;
      check("rnd_dec_op", 64'(bus32.ALUCtrl_o), 64'(exp_dec[2:0]));
      check("rnd_dec_ill", 64'(bus32.illegal_o), 64'(bus32.valid_i & exp_dec[3]));
      check("rnd_dec_nostall", 64'(bus32.stall_o), 64'd0);
    end
    idle_inputs();

    // Basic MUL, then verify no restart from DONE.
    mul32(32'd7, 32'd6);
    after_done32();
    // Signed wrap.
    mul32(32'hFFFF_FFFF, 32'h0000_0003);
    after_done32();
    // Back-to-back random MULs: second starts in the IDLE cycle after DONE.
    mul32($urandom, $urandom);
    mul32($urandom, $urandom);
    after_done32();

    // Narrow instance with 4 bits per cycle.
    mul16(16'h1234, 16'h0010);
    mul16(16'($urandom), 16'($urandom));
    @(posedge clk); #1; bus16.valid_i = 1'b0;

    // Flush at BUSY cycle 10.
    @(posedge clk); #1;
    bus32.valid_i = 1'b1; bus32.ALUOp_i = 3'b010; bus32.funct_i = 6'h18;
    bus32.data1_i = 32'd1234; bus32.data2_i = 32'd5678;
    repeat (10) @(posedge clk);
    #1; bus32.flush_i = 1'b1; #1;
    check("flush_cycle_stall", 64'(bus32.stall_o), 64'd0);
    check("flush_cycle_done", 64'(bus32.done_o), 64'd0);
    @(posedge clk); #1;
    bus32.flush_i = 1'b0; bus32.valid_i = 1'b0; #1;
    check("flush_idle_stall", 64'(bus32.stall_o), 64'd0);
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #2;
      if (bus32.done_o !== 1'b0 || bus32.stall_o !== 1'b0) seen_done++;
    end
    check("flush_no_done", 64'(seen_done), 64'd0);
    mul32($urandom, $urandom);
    after_done32();

    // Reset mid-BUSY, with the MUL still presented.
    mul32(32'd3, 32'd9);
    @(posedge clk); #1;
    bus32.valid_i = 1'b1; bus32.ALUOp_i = 3'b010; bus32.funct_i = 6'h18;
    bus32.data1_i = 32'd100; bus32.data2_i = 32'd200;
    repeat (5) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    check("midrst_stall", 64'(bus32.stall_o), 64'd0);
    check("midrst_done", 64'(bus32.done_o), 64'd0);
    check("midrst_result", 64'(bus32.mul_result_o), 64'd0);
    bus32.valid_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    mul32(32'd5, 32'd5);
    after_done32();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_mc.md
Name: alu_ctrl_mc

Overview:
- Next-generation ALU control for the EX stage. Decodes ALUOp/funct into an ALU operation code, as the single-cycle control does.
- Adds a parametrised iterative multiplier sequencer: MUL ops run for WIDTH/MUL_BPC cycles while stall_o holds the pipeline.
- Flags undecodable funct codes instead of holding a stale ALUCtrl value.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and >= 8.
- MUL_BPC, 1, multiplier bits retired per cycle; must divide WIDTH. Values allowed: 1, 2, 4.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  EX-stage instruction valid.
- flush_i  in  1  abort any in-flight MUL (branch/exception flush).
- ALUOp_i  in  3  main-control ALU op class.
- funct_i  in  6  R-type funct field.
- data1_i  in  WIDTH  multiplicand (rs).
- data2_i  in  WIDTH  multiplier (rt).
- ALUCtrl_o  out  3  decoded ALU op; combinational.
- illegal_o  out  1  valid R-type with unknown funct; combinational.
- stall_o  out  1  hold IF/ID/EX; combinational.
- done_o  out  1  MUL result valid this cycle; registered.
- mul_result_o  out  WIDTH  low WIDTH bits of product; registered.

Behaviour:
- Decode, combinational:
  - ALUOp_i=000 -> ADD(000).
  - ALUOp_i=001 -> SUB(001).
  - Otherwise decode funct_i: 100000 ADD, 100010 SUB, 100100 AND(010), 100101 OR(011), 101010 SLT(100), 011000 MUL(101).
  - Any other funct -> ALUCtrl_o=ADD, and illegal_o=valid_i.
  - No latched outputs.
- start = valid_i & ~flush_i & (ALUCtrl_o==MUL) & (state==IDLE).
- FSM states IDLE, BUSY, DONE. Reset state is IDLE.
  - IDLE:
    - On start: latch data1_i/data2_i, clear the 2*WIDTH accumulator, set cnt=WIDTH/MUL_BPC, go to BUSY.
    - stall_o=start, asserted the same cycle.
  - BUSY:
    - Each cycle, shift-add MUL_BPC multiplier bits into the accumulator and decrement cnt.
    - When cnt reaches 1 this cycle, go to DONE.
    - stall_o=1.
  - DONE:
    - done_o=1 and mul_result_o valid; stall_o=0, so the pipeline advances.
    - Next state is always IDLE.
    - The held MUL instruction is still present on the inputs this cycle and must NOT restart.
- Latency: start cycle to done_o = WIDTH/MUL_BPC + 1 edges. With the defaults, 33 cycles.
- Arithmetic:
  - Unsigned shift-add.
  - The low WIDTH bits equal the two's-complement product, so signedness is irrelevant for mul_result_o.
- Operand capture:
  - data1_i/data2_i are sampled only at start.
  - Input changes during BUSY are ignored.
- flush_i:
  - In BUSY, flush_i forces IDLE next cycle, with no done_o and stall_o=0 in the flush cycle.
  - In IDLE, flush_i suppresses start.
  - In DONE, flush_i has no effect.
- Back-to-back MULs: the second MUL starts in the IDLE cycle after DONE. One non-stalled cycle separates them.
- Non-MUL ops never stall. ALUCtrl_o keeps tracking the inputs in all states.
- Reset:
  - Asserting rst_n_i low at any time, including mid-BUSY, immediately returns the FSM to IDLE.
  - Reset values: done_o=0, mul_result_o=0, accumulator and cnt cleared, stall_o=0.

Optional Feature:
- Macro: ALU_CTRL_HI_EN.
- Defined:
  - Adds output hi_o [WIDTH], registered: the upper WIDTH bits of the unsigned product, valid with done_o.
  - Funct 011001 (MULTU) also decodes to MUL.
  - Reset value of hi_o is 0.
- Undefined:
  - No hi_o port.
  - The accumulator keeps the full 2*WIDTH for the shift-add, but the upper half is not output.
  - 011001 is illegal.

Test Plan:
- Decode sweep:
  - ALUOp=010 with each legal funct -> expected ALUCtrl_o and illegal_o=0.
  - funct=000111 with valid_i=1 -> ALUCtrl_o=000, illegal_o=1.
  - ALUOp=000 and 001 -> ADD and SUB regardless of funct.
- MUL default params:
  - data1=7, data2=6 -> stall_o high for 33 cycles starting at the start cycle.
  - DONE cycle: done_o=1, mul_result_o=42, stall_o=0.
  - Following cycle: IDLE, no restart.
- Signed wrap:
  - data1=0xFFFFFFFF, data2=0x00000003 -> mul_result_o=0xFFFFFFFD.
  - With ALU_CTRL_HI_EN: hi_o=0x00000002.
- Parametrised: WIDTH=16, MUL_BPC=4, data1=0x1234, data2=0x0010 -> done_o at 5 edges after start, mul_result_o=0x2340.
- Flush: assert flush_i at BUSY cycle 10 -> IDLE next cycle, stall_o=0, done_o never asserted; the next MUL starts cleanly.
- Reset: rst_n_i low mid-BUSY -> stall_o, done_o, mul_result_o = 0 immediately. After release, a MUL 5*5 -> 25.
